preg_free_list: RTL

//   Allocator for the physical register file of the out-of-order core. Holds

---
 rtl/preg_free_list_if.sv | 26 ++
 rtl/preg_free_list.sv | 76 +++++++
 2 files changed

// File: rtl/preg_free_list_if.sv
// Rename/retire-facing bundle of the physical register free list.
interface preg_free_list_if #(
  parameter int PREG_W = 6
);
  logic              alloc_req;
  logic              alloc_gnt;
  logic [PREG_W-1:0] alloc_preg;
  logic              free_valid;
  logic [PREG_W-1:0] free_preg;
  logic [PREG_W:0]   free_count;
  logic              empty;
  logic              full;
  logic              overflow_err;

  // Free-list side
  modport slave (
    input  alloc_req, free_valid, free_preg,
    output alloc_gnt, alloc_preg, free_count, empty, full, overflow_err
  );

  // Rename/retire side
  modport master (
    output alloc_req, free_valid, free_preg,
    input  alloc_gnt, alloc_preg, free_count, empty, full, overflow_err
  );
endinterface

// File: rtl/preg_free_list.sv
// Physical register free list: circular FIFO of free tags, one allocation
// and one free per cycle. Tags NUM_AREGS..NUM_PREGS-1 are free at reset.
module preg_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int PREG_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  preg_free_list_if.slave    fl
);
  localparam int DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PREG_W + 1;

  logic [PREG_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              empty_w, full_w, gnt_w, free_ok, free_acc, free_drop;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CNT_W'(DEPTH));

  // Grant is combinational so rename gets its tag in the request cycle;
  // no empty-list bypass from a same-cycle free.
  assign gnt_w     = fl.alloc_req & ~empty_w & ~rst;
  // Tag 0 is hard-wired to x0 and never re-enters the list (no error either).
  assign free_ok   = fl.free_valid & ~rst & (fl.free_preg != '0);
  // A full list can still take a free when a grant drains a slot the same edge.
  assign free_acc  = free_ok & ~(full_w & ~gnt_w);
  assign free_drop = free_ok & full_w & ~gnt_w;

  assign fl.alloc_gnt    = gnt_w;
  assign fl.alloc_preg   = mem_q[head_q];
  assign fl.free_count   = count_q;
  assign fl.empty        = empty_w;
  assign fl.full         = full_w;
  assign fl.overflow_err = ovf_q;

  // Next-state for pointers, occupancy and the sticky overflow flag
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q | free_drop;
    if (gnt_w)
      head_d = (head_q == PTR_W'(DEPTH-1)) ? '0 : head_q + 1'b1;
    if (free_acc)
      tail_d = (tail_q == PTR_W'(DEPTH-1)) ? '0 : tail_q + 1'b1;
    case ({gnt_w, free_acc})
      2'b10:   count_d = count_q - 1'b1;
      2'b01:   count_d = count_q + 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset reloads the initial free tags and drops all state
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CNT_W'(DEPTH);
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= PREG_W'(NUM_AREGS + i);
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (free_acc)
        mem_q[tail_q] <= fl.free_preg;
    end
  end
endmodule
